commit_retire: RTL

- Consumer end of the ROB commit interface. Accepts up to 4 in-order committed instructions per cycle.
- Writes their results into the architectural register file (x0..x31) and maintains a 64-bit retired-instruction counter.
- Drives the debug PC/instruction/halt outputs and detects EBREAK to stop retirement.
- Sits between the reorder buffer commit ports and the top-level debug outputs. Also serves as the architectural state used for verification.

---
 rtl/commit_retire.sv | 100 ++++++++++
 1 files changed

// File: rtl/commit_retire.sv
// commit_retire: retires up to LANES in-order commits per cycle into x0..x31, counts instret, drives debug outputs, halts on EBREAK.
// Ports:
//   clk, reset (async, active-low)
//   commit_valid / commit_pc_flat / commit_inst_flat / commit_data_flat : per-lane commit, lane 0 oldest
//   rd_addr_a/b -> rd_data_a/b : combinational architectural register reads
//   instret : 64-bit retired count; debug_pc/debug_inst : youngest retired last cycle
//   debug_halt : set once EBREAK retires; commit_err : one-cycle pulse on non-contiguous valid
module commit_retire #(
    parameter int          LANES     = 4,
    parameter int          XLEN      = 32,
    parameter int          PCW       = 64,
    parameter logic [31:0] HALT_INST = 32'h00100073
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES-1:0]      commit_valid,
    input  logic [LANES*PCW-1:0]  commit_pc_flat,
    input  logic [LANES*32-1:0]   commit_inst_flat,
    input  logic [LANES*XLEN-1:0] commit_data_flat,
    input  logic [4:0]            rd_addr_a,
    output logic [XLEN-1:0]       rd_data_a,
    input  logic [4:0]            rd_addr_b,
    output logic [XLEN-1:0]       rd_data_b,
    output logic [63:0]           instret,
    output logic [PCW-1:0]        debug_pc,
    output logic [31:0]           debug_inst,
    output logic                  debug_halt,
    output logic                  commit_err
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t                 state_q, state_d;
    logic [31:0][XLEN-1:0]  rf_q, rf_d;
    logic [63:0]            instret_q, instret_d;
    logic [PCW-1:0]         pc_q, pc_d;
    logic [31:0]            inst_q, inst_d;
    logic                   err_q, err_d;
    logic                   live, gap;

    // Lanes are scanned oldest first; "live" drops at the first invalid lane
    // or after a HALT_INST lane, so later lanes cannot retire. Later lanes
    // overwrite rf_d, giving the youngest lane priority on a shared rd.
    always_comb begin
        state_d   = state_q;
        rf_d      = rf_q;
        instret_d = instret_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        err_d     = 1'b0;
        live      = (state_q == RUN);
        gap       = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!commit_valid[i])
                gap = 1'b1;
            else if (gap)
                err_d = (state_q == RUN);
            live = live & commit_valid[i];
            if (live) begin
                instret_d = instret_d + 64'd1;
                pc_d      = commit_pc_flat[i*PCW +: PCW];
                inst_d    = commit_inst_flat[i*32 +: 32];
                if ((commit_inst_flat[i*32 +: 7] inside {7'b0110111, 7'b0010111, 7'b1101111,
                     7'b1100111, 7'b0000011, 7'b0010011, 7'b0110011})
                    && commit_inst_flat[i*32+7 +: 5] != 5'd0)
                    rf_d[commit_inst_flat[i*32+7 +: 5]] = commit_data_flat[i*XLEN +: XLEN];
                if (commit_inst_flat[i*32 +: 32] == HALT_INST) begin
                    live    = 1'b0;
                    state_d = HALTED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            rf_q      <= '0;
            instret_q <= '0;
            pc_q      <= '0;
            inst_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rf_q      <= rf_d;
            instret_q <= instret_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            err_q     <= err_d;
        end
    end

    // x0 is never written, so it reads zero without a special case.
    assign rd_data_a  = rf_q[rd_addr_a];
    assign rd_data_b  = rf_q[rd_addr_b];
    assign instret    = instret_q;
    assign debug_pc   = pc_q;
    assign debug_inst = inst_q;
    assign debug_halt = (state_q == HALTED);
    assign commit_err = err_q;
endmodule
